step_pulse_gen: RTL and testbench

//  Consumes the debounced push-button level (pbreg, produced on the 1 ms tick

---
 rtl/step_pulse_gen.sv | 152 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// ---------------------------------------------------------------------------
// step_pulse_gen
//
// Turns the debounced push-button level into single-cycle step pulses in the
// CPU clock domain. Each press issues one pulse. If auto-repeat is enabled and
// the button stays held, a second pulse follows HOLD_CYCLES clocks after the
// first. Further pulses then follow every REPEAT_CYCLES clocks. A wrapping
// count of issued pulses is kept for the display.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   pb_level    debounced button level, asynchronous to clk
//   repeat_en   1 = auto-repeat while held, 0 = one pulse per press
//   step        one-cycle step pulse (registered)
//   held        1 while the FSM is not IDLE (registered)
//   step_count  number of step pulses issued, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_level,
    input  logic             repeat_en,
    output logic             step,
    output logic             held,
    output logic [CNT_W-1:0] step_count
);

    // The timer only ever has to reach max(HOLD, REPEAT) - 1.
    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        REPEAT,
        WAIT_REL
    } state_t;

    state_t                 state;
    logic [TIMER_W-1:0]     timer;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   pb_sync;
    logic                   pb_prev;
    logic                   rise;

    // Synchronizer plus one delay flop for edge detection. Both are cleared by
    // reset. A button held through reset release therefore shows up as a new
    // rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
            pb_prev    <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pb_level};
            pb_prev    <= pb_sync;
        end
    end

    assign pb_sync = sync_chain[SYNC_STAGES-1];
    assign rise    = pb_sync & ~pb_prev;

    // Press/repeat FSM. In ARM and REPEAT, release is tested first and
    // repeat_en second. Either one therefore wins over a timer expiry in the
    // same cycle. held tracks the state being entered, so it rises together
    // with the first pulse. It falls on the edge that returns the FSM to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            step       <= 1'b0;
            held       <= 1'b0;
            step_count <= '0;
        end else begin
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        step       <= 1'b1;
                        step_count <= step_count + 1'b1;
                        timer      <= '0;
                        state      <= ARM;
                        held       <= 1'b1;
                    end else begin
                        held <= 1'b0;
                    end
                end

                ARM: begin
                    if (!pb_sync) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end else if (!repeat_en) begin
                        state <= WAIT_REL;
                        held  <= 1'b1;
                    end else if (timer == HOLD_LAST) begin
                        step       <= 1'b1;
                        step_count <= step_count + 1'b1;
                        timer      <= '0;
                        state      <= REPEAT;
                        held       <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                        held  <= 1'b1;
                    end
                end

                REPEAT: begin
                    if (!pb_sync) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end else if (!repeat_en) begin
                        state <= WAIT_REL;
                        held  <= 1'b1;
                    end else if (timer == REPEAT_LAST) begin
                        step       <= 1'b1;
                        step_count <= step_count + 1'b1;
                        timer      <= '0;
                        held       <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                        held  <= 1'b1;
                    end
                end

                // Re-enabling repeat here is ignored; only a new press counts.
                WAIT_REL: begin
                    if (!pb_sync) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end else begin
                        held <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_step_pulse_gen
//
// Directed bench for step_pulse_gen with HOLD_CYCLES=8, REPEAT_CYCLES=4 and
// CNT_W=4. Inputs change 1 ns after a rising edge and are sampled by the next
// edge. Outputs are checked at that same point, 1 ns after the edge.
// "tick n" means the n-th rising edge after the inputs were set. With two sync
// stages, the first pulse of a press lands on tick 3.
// ---------------------------------------------------------------------------
module tb_step_pulse_gen;

    logic       clk;
    logic       rst;
    logic       pb_level;
    logic       repeat_en;
    logic       step;
    logic       held;
    logic [3:0] step_count;

    int checks;
    int errors;
    int pulses;

    step_pulse_gen #(
        .SYNC_STAGES  (2),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_level  (pb_level),
        .repeat_en (repeat_en),
        .step      (step),
        .held      (held),
        .step_count(step_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all DUT inputs at once.
    task automatic applyStimulus(input logic r, input logic pb, input logic rep);
        rst       = r;
        pb_level  = pb;
        repeat_en = rep;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Put the DUT into a clean idle state with the button released.
    task automatic resetDut(input logic rep);
        applyStimulus(1'b1, 1'b0, rep);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);

        // 1: button held through reset; outputs stay 0 during reset.
        //    The first pulse comes 3 clocks after release.
        $display("[TB] test 1: press held through reset");
        tick();
        tick();
        checkOutput("t1_rst_step", step, 0);
        checkOutput("t1_rst_held", held, 0);
        checkOutput("t1_rst_count", step_count, 0);
        rst = 1'b0;
        tick();
        checkOutput("t1_tick1_step", step, 0);
        tick();
        checkOutput("t1_tick2_step", step, 0);
        tick();
        checkOutput("t1_tick3_step", step, 1);
        checkOutput("t1_tick3_held", held, 1);
        checkOutput("t1_tick3_count", step_count, 1);
        tick();
        checkOutput("t1_tick4_step", step, 0);
        checkOutput("t1_tick4_count", step_count, 1);

        // 2: no repeat; a 50-clock press gives exactly one pulse. Raising
        //    repeat_en mid-press (in WAIT_REL) changes nothing.
        //    held drops 3 ticks after release.
        $display("[TB] test 2: single pulse per press");
        resetDut(1'b0);
        pb_level = 1'b1;
        pulses   = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 3) checkOutput("t2_first_step", step, 1);
            if (step) pulses++;
            if (i == 20) repeat_en = 1'b1;
        end
        checkOutput("t2_held_while_pressed", held, 1);
        pb_level = 1'b0;
        tick();
        checkOutput("t2_rel1_held", held, 1);
        tick();
        checkOutput("t2_rel2_held", held, 1);
        tick();
        checkOutput("t2_rel3_held", held, 0);
        checkOutput("t2_pulses", pulses, 1);
        checkOutput("t2_count", step_count, 1);

        // 3: repeat held. Pulses at ticks 3, 11, 15, 19, 23, 27, 31.
        //    Release after tick 31; the FSM sees it at tick 34.
        $display("[TB] test 3: auto-repeat timing");
        resetDut(1'b1);
        pb_level = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checkOutput($sformatf("t3_step_%0d", i), step,
                        (i == 3 || i == 11 || i == 15 || i == 19 ||
                         i == 23 || i == 27 || i == 31) ? 1 : 0);
            checkOutput($sformatf("t3_held_%0d", i), held,
                        (i >= 3 && i <= 33) ? 1 : 0);
            if (i == 31) pb_level = 1'b0;
        end
        checkOutput("t3_count", step_count, 7);

        // 4: release reaches pb_sync exactly when the ARM timer reads 7 (tick 11).
        //    There is no second pulse, and the FSM returns to IDLE.
        $display("[TB] test 4: release beats hold expiry");
        resetDut(1'b1);
        pb_level = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checkOutput($sformatf("t4_step_%0d", i), step, (i == 3) ? 1 : 0);
            checkOutput($sformatf("t4_held_%0d", i), held,
                        (i >= 3 && i <= 10) ? 1 : 0);
            if (i == 8) pb_level = 1'b0;
        end
        checkOutput("t4_count", step_count, 1);

        // 5: 17 short presses (2 high, 3 low). Each press gives one pulse on its
        //    3rd tick. The 4-bit count wraps 15 -> 0 -> 1.
        $display("[TB] test 5: count wrap");
        resetDut(1'b1);
        pulses = 0;
        for (int k = 1; k <= 17; k++) begin
            for (int j = 1; j <= 5; j++) begin
                pb_level = (j <= 2) ? 1'b1 : 1'b0;
                tick();
                if (step) pulses++;
                if (j == 3) checkOutput($sformatf("t5_step_press%0d", k), step, 1);
            end
            checkOutput($sformatf("t5_count_press%0d", k), step_count, k % 16);
        end
        checkOutput("t5_pulses", pulses, 17);

        // 6: reset asserted during a REPEAT pulse clears the outputs immediately.
        //    After release with the button still held, a new first pulse
        //    comes 3 clocks later.
        $display("[TB] test 6: async reset mid-repeat");
        resetDut(1'b1);
        pb_level = 1'b1;
        for (int i = 1; i <= 15; i++) tick();
        checkOutput("t6_pre_step", step, 1);
        checkOutput("t6_pre_count", step_count, 3);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_step", step, 0);
        checkOutput("t6_async_held", held, 0);
        checkOutput("t6_async_count", step_count, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t6_tick1_step", step, 0);
        tick();
        checkOutput("t6_tick2_step", step, 0);
        tick();
        checkOutput("t6_tick3_step", step, 1);
        checkOutput("t6_tick3_count", step_count, 1);
        checkOutput("t6_tick3_held", held, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
